obstacle_scheduler: RTL and testbench
=====================================

Name: obstacle_scheduler

Overview:
Parametrised multi-channel obstacle manager. Runs NUM_OBS independent obstacle lanes, with per-lane active flags and RNG-driven spawn spacing and type selection. Scroll speed ramps up with game time. Runs on the pixel clock and advances on the one-cycle 60 Hz game-tick pulse. Feeds obs_render/obs_rom instances (one per lane) and is gated by player_controller's start and frozen signals.

Parameters:
NUM_OBS, 3, number of obstacle lanes (1..8)
CONV, 2, coordinate shift; position width POS_W = 10-CONV
SPAWN_X, 160, spawn position in converted units (right screen edge)
PARK_POS, 2**POS_W-1, position driven for inactive lanes
MIN_GAP, 40, minimum scrolled distance between spawns
NUM_TYPES, 5, number of valid obstacle types (1..8)
SPEED_INIT, 1, scroll step per tick after start
SPEED_MAX, 4, speed saturation value (<=7)
SPEED_STEP_TICKS, 600, RUN ticks per speed increment

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
i_game_tick  in  1  one-clk pulse, 60 Hz
i_game_start_pulse  in  1  one-clk pulse, start/restart
i_game_frozen  in  1  level, game over/paused
i_rng  in  8  free-running LFSR value
o_obs_pos  out  NUM_OBS*POS_W  packed lane positions, lane 0 in LSBs
o_obs_type  out  NUM_OBS*3  packed lane types
o_obs_active  out  NUM_OBS  lane active flags
o_speed  out  3  current scroll speed
o_spawn_pulse  out  1  one-clk pulse per spawn

Behaviour:
- Reset values (also applied by "clear"):
  - all pos = PARK_POS, all type = 0, active = 0
  - speed = SPEED_INIT, spawn_pulse = 0, tick counter = 0
  - gap = 255 (saturated), threshold = MIN_GAP
  - FSM = IDLE
- All outputs are registered. A tick's effects are visible the clk cycle after i_game_tick is high.
- FSM states IDLE, RUN, FROZEN:
  - IDLE: start -> clear, go to RUN.
  - RUN: start -> clear, stay in RUN. Else frozen -> FROZEN, and a tick in that same cycle is ignored.
  - FROZEN: start -> clear, go to RUN. All state held.
  - Start has priority over frozen and tick. A tick coincident with start is ignored.
- Ticks in IDLE or FROZEN are ignored.
- rst has priority over everything, at any time.
- Per tick in RUN, evaluated from the pre-tick state:
  - Move: each active lane with pos >= speed does pos -= speed. An active lane with pos < speed retires: active = 0, pos = PARK_POS, type held.
  - Gap: gap_next = min(gap + speed, 255).
  - Spawn condition: gap_next >= threshold AND a lane was inactive before this tick. A lane retiring on this tick is not eligible until the next tick.
  - Spawn action, in the lowest-index eligible lane:
    - active = 1, pos = SPAWN_X (not moved on the spawn tick)
    - type = i_rng[2:0] if < NUM_TYPES, else i_rng[2:0] - NUM_TYPES
    - gap = 0, threshold = MIN_GAP + i_rng[7:4]
    - spawn_pulse = 1 for exactly one clk
  - No spawn: gap = gap_next. The spawn is deferred, with gap saturating, until a lane frees.
  - Speed: the tick counter increments each RUN tick. At SPEED_STEP_TICKS-1 it wraps to 0 and speed = min(speed + 1, SPEED_MAX).
- The first RUN tick after start always spawns into lane 0, because gap starts saturated.
- Width rules:
  - positions are unsigned POS_W bits and never wrap below 0
  - gap is 8-bit saturating
  - threshold is 8 bits (MIN_GAP + 15 <= 255 required)

Test Plan:
1. Reset, then 5 ticks with no start -> o_obs_active=000, every pos=255, o_speed=1, o_spawn_pulse never high.
2. Start, then tick with i_rng=8'h52 -> lane0 active, pos=160, type=2, one-clk spawn_pulse; threshold=45. On the following ticks lane0 = 159, 158, ... Lane1 spawns on the 45th tick after, when lane0 = 115.
3. i_rng[2:0]=7 at spawn with NUM_TYPES=5 -> type=2. Start and tick in the same cycle -> cleared state, no movement, no spawn.
4. RUN with lanes moving, assert frozen, 10 ticks -> all outputs unchanged. Start -> all lanes inactive at 255, speed=1; next tick spawns lane0.
5. Lane at pos=0, speed=1, gap satisfied, all 3 lanes active -> that lane retires to 255 with no spawn this tick; spawn into it on the next tick.
6. 600 RUN ticks -> o_speed=2; 1800 ticks -> 4; 3000 ticks -> still 4. With all lanes held active, gap saturates at 255 and no spawn_pulse occurs.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: multi-lane obstacle manager for the runner game.
// Each lane scrolls left by the current speed on every game tick while
// the game runs. New obstacles are spawned into the lowest free lane once
// enough distance has scrolled past. Spacing and type come from the LFSR,
// and speed ramps up with elapsed run time. All outputs are registered.
module obstacle_scheduler #(
  parameter int NUM_OBS          = 3,
  parameter int CONV             = 2,
  parameter int POS_W            = 10 - CONV,
  parameter int SPAWN_X          = 160,
  parameter int PARK_POS         = (1 << POS_W) - 1,
  parameter int MIN_GAP          = 40,
  parameter int NUM_TYPES        = 5,
  parameter int SPEED_INIT       = 1,
  parameter int SPEED_MAX        = 4,
  parameter int SPEED_STEP_TICKS = 600
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_game_tick,
  input  logic                     i_game_start_pulse,
  input  logic                     i_game_frozen,
  input  logic [7:0]               i_rng,
  output logic [NUM_OBS*POS_W-1:0] o_obs_pos,
  output logic [NUM_OBS*3-1:0]     o_obs_type,
  output logic [NUM_OBS-1:0]       o_obs_active,
  output logic [2:0]               o_speed,
  output logic                     o_spawn_pulse
);

  localparam int CNT_W = (SPEED_STEP_TICKS > 1) ? $clog2(SPEED_STEP_TICKS) : 1;

  localparam logic [POS_W-1:0] PARK_V       = POS_W'(PARK_POS);
  localparam logic [POS_W-1:0] SPAWN_V      = POS_W'(SPAWN_X);
  localparam logic [2:0]       SPEED_INIT_V = 3'(SPEED_INIT);
  localparam logic [2:0]       SPEED_MAX_V  = 3'(SPEED_MAX);
  localparam logic [7:0]       MIN_GAP_V    = 8'(MIN_GAP);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SPEED_STEP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  // Folds a raw 3-bit random value into the valid type range.
  function automatic logic [2:0] map_type(input logic [2:0] raw);
    logic [2:0] res;
    if (raw < 3'(NUM_TYPES)) begin
      res = raw;
    end else begin
      res = raw - 3'(NUM_TYPES);
    end
    return res;
  endfunction

  state_e state_q, state_d;

  logic [POS_W-1:0] pos_q  [NUM_OBS];
  logic [POS_W-1:0] pos_d  [NUM_OBS];
  logic [2:0]       type_q [NUM_OBS];
  logic [2:0]       type_d [NUM_OBS];
  logic [NUM_OBS-1:0] active_q, active_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       thr_q, thr_d;
  logic [2:0]       speed_q, speed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  logic               clear_s;
  logic               tick_run_s;
  logic [8:0]         gap_sum_s;
  logic [7:0]         gap_next_s;
  logic               spawn_s;
  logic [NUM_OBS-1:0] spawn_sel_s;
  logic               taken_s;
  logic               rng_unused_s;

  // Bit 3 of the random value plays no role in type or spacing selection.
  assign rng_unused_s = i_rng[3];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start always wins, frozen only matters while running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_game_start_pulse) state_d = ST_RUN;
        else                    state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (i_game_start_pulse) state_d = ST_RUN;
        else if (i_game_frozen) state_d = ST_FROZEN;
        else                    state_d = ST_RUN;
      end
      ST_FROZEN: begin
        if (i_game_start_pulse) state_d = ST_RUN;
        else                    state_d = ST_FROZEN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: clear on any start, advance only on a clean RUN tick.
  always_comb begin
    clear_s    = i_game_start_pulse;
    tick_run_s = 1'b0;
    if ((state_q == ST_RUN) && !i_game_start_pulse && !i_game_frozen && i_game_tick) begin
      tick_run_s = 1'b1;
    end else begin
      tick_run_s = 1'b0;
    end
  end

  // Saturating gap accumulation and spawn decision from pre-tick state.
  always_comb begin
    gap_sum_s  = {1'b0, gap_q} + {6'd0, speed_q};
    gap_next_s = gap_sum_s[8] ? 8'hFF : gap_sum_s[7:0];
    spawn_s    = (gap_next_s >= thr_q) && (|(~active_q));
  end

  // One-hot pick of the lowest lane that was free before this tick.
  always_comb begin
    taken_s     = 1'b0;
    spawn_sel_s = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (!active_q[i] && !taken_s) begin
        spawn_sel_s[i] = 1'b1;
        taken_s        = 1'b1;
      end else begin
        spawn_sel_s[i] = 1'b0;
      end
    end
  end

  // Datapath next state: clear, per-tick move/retire/spawn/speed, or hold.
  always_comb begin
    for (int i = 0; i < NUM_OBS; i++) begin
      pos_d[i]  = pos_q[i];
      type_d[i] = type_q[i];
    end
    active_d = active_q;
    gap_d    = gap_q;
    thr_d    = thr_q;
    speed_d  = speed_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (clear_s) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_d[i]  = PARK_V;
        type_d[i] = 3'd0;
      end
      active_d = '0;
      gap_d    = 8'hFF;
      thr_d    = MIN_GAP_V;
      speed_d  = SPEED_INIT_V;
      cnt_d    = '0;
    end else if (tick_run_s) begin
      // A lane retiring here stays free until the next tick.
      for (int i = 0; i < NUM_OBS; i++) begin
        if (active_q[i]) begin
          if (pos_q[i] >= POS_W'(speed_q)) begin
            pos_d[i] = pos_q[i] - POS_W'(speed_q);
          end else begin
            active_d[i] = 1'b0;
            pos_d[i]    = PARK_V;
          end
        end else if (spawn_s && spawn_sel_s[i]) begin
          active_d[i] = 1'b1;
          pos_d[i]    = SPAWN_V;
          type_d[i]   = map_type(i_rng[2:0]);
        end else begin
          pos_d[i] = pos_q[i];
        end
      end
      if (spawn_s) begin
        gap_d   = 8'd0;
        thr_d   = MIN_GAP_V + {4'd0, i_rng[7:4]};
        pulse_d = 1'b1;
      end else begin
        gap_d = gap_next_s;
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (speed_q < SPEED_MAX_V) speed_d = speed_q + 3'd1;
        else                       speed_d = speed_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      pulse_d = 1'b0;
    end
  end

  // Datapath registers with synchronous reset to the cleared state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_q[i]  <= PARK_V;
        type_q[i] <= 3'd0;
      end
      active_q <= '0;
      gap_q    <= 8'hFF;
      thr_q    <= MIN_GAP_V;
      speed_q  <= SPEED_INIT_V;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_q[i]  <= pos_d[i];
        type_q[i] <= type_d[i];
      end
      active_q <= active_d;
      gap_q    <= gap_d;
      thr_q    <= thr_d;
      speed_q  <= speed_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
    assign o_obs_pos[g*POS_W +: POS_W] = pos_q[g];
    assign o_obs_type[g*3 +: 3]        = type_q[g];
  end

  assign o_obs_active  = active_q;
  assign o_speed       = speed_q;
  assign o_spawn_pulse = pulse_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed self-checking bench for obstacle_scheduler (default parameters:
// 3 lanes, 8-bit positions, spawn at 160, park at 255, gap 40, 5 types).
module tb_obstacle_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_game_tick;
  logic        i_game_start_pulse;
  logic        i_game_frozen;
  logic [7:0]  i_rng;
  logic [23:0] o_obs_pos;
  logic [8:0]  o_obs_type;
  logic [2:0]  o_obs_active;
  logic [2:0]  o_speed;
  logic        o_spawn_pulse;

  int total = 0;
  int bad   = 0;

  localparam logic [39:0] CLEARED = {3'b000, 24'hFFFFFF, 9'd0, 3'd1, 1'b0};

  obstacle_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .i_game_tick        (i_game_tick),
    .i_game_start_pulse (i_game_start_pulse),
    .i_game_frozen      (i_game_frozen),
    .i_rng              (i_rng),
    .o_obs_pos          (o_obs_pos),
    .o_obs_type         (o_obs_type),
    .o_obs_active       (o_obs_active),
    .o_speed            (o_speed),
    .o_spawn_pulse      (o_spawn_pulse)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Drive one tick pulse; returns at the negedge after it was registered.
  task automatic tick(input logic [7:0] r);
    @(negedge clk);
    i_rng       = r;
    i_game_tick = 1'b1;
    @(negedge clk);
    i_game_tick = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk);
    i_game_start_pulse = 1'b1;
    @(negedge clk);
    i_game_start_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({o_obs_active, o_obs_pos, o_obs_type, o_speed, o_spawn_pulse} !== CLEARED) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h",
               {o_obs_active, o_obs_pos, o_obs_type, o_speed, o_spawn_pulse}, CLEARED);
    end
    for (int k = 0; k < 5; k++) begin
      tick(8'h52);
      total++;
      if ({o_obs_active, o_obs_pos, o_speed, o_spawn_pulse} !== {3'b000, 24'hFFFFFF, 3'd1, 1'b0}) begin
        bad++;
        $display("FAIL idle_tick%0d got act=%b pos=%h spd=%0d pulse=%b exp 000/ffffff/1/0",
                 k, o_obs_active, o_obs_pos, o_speed, o_spawn_pulse);
      end
    end
  endtask

  task automatic test_spawn_spacing();
    start_game();
    tick(8'h52);
    total++;
    if ({o_obs_active, o_obs_pos, o_obs_type[2:0], o_spawn_pulse} !==
        {3'b001, 8'hFF, 8'hFF, 8'd160, 3'd2, 1'b1}) begin
      bad++;
      $display("FAIL first_spawn got act=%b pos=%h type0=%0d pulse=%b exp 001/ffffa0/2/1",
               o_obs_active, o_obs_pos, o_obs_type[2:0], o_spawn_pulse);
    end
    @(negedge clk);
    total++;
    if (o_spawn_pulse !== 1'b0) begin
      bad++;
      $display("FAIL pulse_width got=%b exp=0", o_spawn_pulse);
    end
    for (int k = 1; k <= 45; k++) begin
      tick(8'h07);
      if (k <= 2) begin
        total++;
        if (o_obs_pos[7:0] !== 8'(160 - k)) begin
          bad++;
          $display("FAIL lane0_move%0d got=%0d exp=%0d", k, o_obs_pos[7:0], 160 - k);
        end
      end
      if (k == 44) begin
        total++;
        if ({o_obs_active, o_obs_pos[7:0], o_spawn_pulse} !== {3'b001, 8'd116, 1'b0}) begin
          bad++;
          $display("FAIL before_gap got act=%b pos0=%0d pulse=%b exp 001/116/0",
                   o_obs_active, o_obs_pos[7:0], o_spawn_pulse);
        end
      end
      if (k == 45) begin
        total++;
        if ({o_obs_active, o_obs_pos, o_spawn_pulse} !== {3'b011, 8'hFF, 8'd160, 8'd115, 1'b1}) begin
          bad++;
          $display("FAIL second_spawn got act=%b pos=%h pulse=%b exp 011/ffa073/1",
                   o_obs_active, o_obs_pos, o_spawn_pulse);
        end
        total++;
        if (o_obs_type !== {3'd0, 3'd2, 3'd2}) begin
          bad++;
          $display("FAIL type_fold got=%o exp=%o", o_obs_type, {3'd0, 3'd2, 3'd2});
        end
      end
    end
  endtask

  task automatic test_start_with_tick();
    @(negedge clk);
    i_game_start_pulse = 1'b1;
    i_game_tick        = 1'b1;
    i_rng              = 8'h52;
    @(negedge clk);
    i_game_start_pulse = 1'b0;
    i_game_tick        = 1'b0;
    total++;
    if ({o_obs_active, o_obs_pos, o_obs_type, o_speed, o_spawn_pulse} !== CLEARED) begin
      bad++;
      $display("FAIL start_tick_clear got=%h exp=%h",
               {o_obs_active, o_obs_pos, o_obs_type, o_speed, o_spawn_pulse}, CLEARED);
    end
    tick(8'h00);
    total++;
    if ({o_obs_active, o_obs_pos, o_spawn_pulse} !== {3'b001, 8'hFF, 8'hFF, 8'd160, 1'b1}) begin
      bad++;
      $display("FAIL restart_spawn got act=%b pos=%h pulse=%b exp 001/ffffa0/1",
               o_obs_active, o_obs_pos, o_spawn_pulse);
    end
  endtask

  task automatic test_frozen();
    repeat (3) tick(8'h00);
    @(negedge clk);
    i_game_frozen = 1'b1;
    i_game_tick   = 1'b1;
    @(negedge clk);
    i_game_tick   = 1'b0;
    total++;
    if ({o_obs_active, o_obs_pos, o_spawn_pulse} !== {3'b001, 8'hFF, 8'hFF, 8'd157, 1'b0}) begin
      bad++;
      $display("FAIL freeze_same_tick got act=%b pos=%h pulse=%b exp 001/ffff9d/0",
               o_obs_active, o_obs_pos, o_spawn_pulse);
    end
    for (int k = 0; k < 10; k++) begin
      tick(8'h00);
      total++;
      if ({o_obs_active, o_obs_pos, o_speed, o_spawn_pulse} !== {3'b001, 8'hFF, 8'hFF, 8'd157, 3'd1, 1'b0}) begin
        bad++;
        $display("FAIL frozen_hold%0d got act=%b pos=%h spd=%0d pulse=%b exp 001/ffff9d/1/0",
                 k, o_obs_active, o_obs_pos, o_speed, o_spawn_pulse);
      end
    end
    @(negedge clk);
    i_game_start_pulse = 1'b1;
    i_game_frozen      = 1'b0;
    @(negedge clk);
    i_game_start_pulse = 1'b0;
    total++;
    if ({o_obs_active, o_obs_pos, o_obs_type, o_speed, o_spawn_pulse} !== CLEARED) begin
      bad++;
      $display("FAIL unfreeze_clear got=%h exp=%h",
               {o_obs_active, o_obs_pos, o_obs_type, o_speed, o_spawn_pulse}, CLEARED);
    end
    tick(8'h00);
    total++;
    if ({o_obs_active, o_obs_pos, o_spawn_pulse} !== {3'b001, 8'hFF, 8'hFF, 8'd160, 1'b1}) begin
      bad++;
      $display("FAIL unfreeze_spawn got act=%b pos=%h pulse=%b exp 001/ffffa0/1",
               o_obs_active, o_obs_pos, o_spawn_pulse);
    end
  endtask

  task automatic test_retire();
    int pulses_quiet;
    int pulses_all;
    pulses_quiet = 0;
    pulses_all   = 0;
    start_game();
    tick(8'h00);
    for (int k = 1; k <= 162; k++) begin
      tick((k == 162) ? 8'h04 : 8'h01);
      if (o_spawn_pulse === 1'b1) pulses_all++;
      if ((k > 80) && (k <= 161) && (o_spawn_pulse !== 1'b0)) pulses_quiet++;
      if (k == 40) begin
        total++;
        if ({o_obs_active, o_obs_pos, o_spawn_pulse} !== {3'b011, 8'hFF, 8'd160, 8'd120, 1'b1}) begin
          bad++;
          $display("FAIL lane1_spawn got act=%b pos=%h pulse=%b exp 011/ffa078/1",
                   o_obs_active, o_obs_pos, o_spawn_pulse);
        end
      end
      if (k == 80) begin
        total++;
        if ({o_obs_active, o_obs_pos, o_spawn_pulse} !== {3'b111, 8'd160, 8'd120, 8'd80, 1'b1}) begin
          bad++;
          $display("FAIL lane2_spawn got act=%b pos=%h pulse=%b exp 111/a07850/1",
                   o_obs_active, o_obs_pos, o_spawn_pulse);
        end
      end
      if (k == 160) begin
        total++;
        if ({o_obs_active, o_obs_pos, o_spawn_pulse} !== {3'b111, 8'd80, 8'd40, 8'd0, 1'b0}) begin
          bad++;
          $display("FAIL lane0_at_zero got act=%b pos=%h pulse=%b exp 111/502800/0",
                   o_obs_active, o_obs_pos, o_spawn_pulse);
        end
      end
      if (k == 161) begin
        total++;
        if ({o_obs_active, o_obs_pos, o_obs_type, o_spawn_pulse} !==
            {3'b110, 8'd79, 8'd39, 8'hFF, 3'd1, 3'd1, 3'd0, 1'b0}) begin
          bad++;
          $display("FAIL retire got act=%b pos=%h type=%o pulse=%b exp 110/4f27ff/110/0",
                   o_obs_active, o_obs_pos, o_obs_type, o_spawn_pulse);
        end
      end
      if (k == 162) begin
        total++;
        if ({o_obs_active, o_obs_pos, o_obs_type, o_spawn_pulse} !==
            {3'b111, 8'd78, 8'd38, 8'd160, 3'd1, 3'd1, 3'd4, 1'b1}) begin
          bad++;
          $display("FAIL respawn got act=%b pos=%h type=%o pulse=%b exp 111/4e26a0/114/1",
                   o_obs_active, o_obs_pos, o_obs_type, o_spawn_pulse);
        end
      end
    end
    total++;
    if (pulses_quiet !== 0) begin
      bad++;
      $display("FAIL full_no_spawn got=%0d exp=0", pulses_quiet);
    end
    total++;
    if (pulses_all !== 3) begin
      bad++;
      $display("FAIL spawn_count got=%0d exp=3", pulses_all);
    end
  endtask

  task automatic test_speed_ramp();
    start_game();
    for (int k = 1; k <= 3000; k++) begin
      tick(8'h00);
      if ((k == 599) || (k == 600) || (k == 1199) || (k == 1200) ||
          (k == 1799) || (k == 1800) || (k == 3000)) begin
        logic [2:0] exp_spd;
        exp_spd = (k < 600) ? 3'd1 : (k < 1200) ? 3'd2 : (k < 1800) ? 3'd3 : 3'd4;
        total++;
        if (o_speed !== exp_spd) begin
          bad++;
          $display("FAIL speed_at_%0d got=%0d exp=%0d", k, o_speed, exp_spd);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({o_obs_active, o_obs_pos, o_obs_type, o_speed, o_spawn_pulse} !== CLEARED) begin
      bad++;
      $display("FAIL midrun_reset got=%h exp=%h",
               {o_obs_active, o_obs_pos, o_obs_type, o_speed, o_spawn_pulse}, CLEARED);
    end
    tick(8'h00);
    total++;
    if ({o_obs_active, o_spawn_pulse} !== {3'b000, 1'b0}) begin
      bad++;
      $display("FAIL reset_to_idle got act=%b pulse=%b exp 000/0", o_obs_active, o_spawn_pulse);
    end
  endtask

  // Main sequence of directed scenarios.
  initial begin
    rst                = 1'b1;
    i_game_tick        = 1'b0;
    i_game_start_pulse = 1'b0;
    i_game_frozen      = 1'b0;
    i_rng              = 8'h00;
    test_reset();
    test_spawn_spacing();
    test_start_with_tick();
    test_frozen();
    test_retire();
    test_speed_ramp();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
